// File: rtl/cmem_arbiter.sv
// Round-robin arbiter sharing the host memory port between I-side refill and D-side refill/writeback.
// Latency: grant one edge after request in IDLE; dv is combinational with h_dv; 2 idle cycles between grants.
module cmem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_dv,
    output logic [ADDR_W-1:0] h_addr,
    output logic              h_rd,
    output logic              h_wr,
    output logic [LINE_W-1:0] h_data_out,
    input  logic [LINE_W-1:0] h_data_in,
    input  logic              h_dv,
    output logic [ADDR_W-1:0] inv_addr,
    output logic              inv,
    output logic              err
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GNT_I,
        S_GNT_DR,
        S_GNT_DW,
        S_RELEASE
    } state_t;

    localparam logic LS_I = 1'b0;
    localparam logic LS_D = 1'b1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] h_addr_q, h_addr_d;
    logic [LINE_W-1:0] h_data_out_q, h_data_out_d;
    logic [ADDR_W-1:0] inv_addr_q, inv_addr_d;
    logic              inv_q, inv_d;
    logic              err_q, err_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic granted;
    logic done;
    logic pick_i;

    always_comb begin
        state_d      = state_q;
        h_addr_d     = h_addr_q;
        h_data_out_d = h_data_out_q;
        inv_addr_d   = inv_addr_q;
        inv_d        = 1'b0;
        err_d        = err_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        i_dv         = 1'b0;
        d_dv         = 1'b0;
        i_data       = '0;
        d_rdata      = '0;

        granted = (state_q == S_GNT_I) || (state_q == S_GNT_DR) || (state_q == S_GNT_DW);
        // A grant ends on h_dv or on the last allowed wait cycle; reset suppresses completion.
        done    = granted && !rst && (h_dv || (cnt_q == CNT_MAX));
        pick_i  = i_rd && (!(d_rd || d_wr) || (last_q == LS_D));

        case (state_q)
            S_IDLE: begin
                if (pick_i) begin
                    state_d  = S_GNT_I;
                    h_addr_d = i_addr & ALIGN_MASK;
                    last_d   = LS_I;
                    cnt_d    = '0;
                end else if (d_rd || d_wr) begin
                    state_d  = d_wr ? S_GNT_DW : S_GNT_DR;
                    h_addr_d = d_addr & ALIGN_MASK;
                    if (d_wr) begin
                        h_data_out_d = d_wdata;
                    end
                    last_d   = LS_D;
                    cnt_d    = '0;
                end
            end
            S_GNT_I, S_GNT_DR, S_GNT_DW: begin
                if (done) begin
                    state_d = S_RELEASE;
                    if (!h_dv) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done) begin
            if (state_q == S_GNT_I) begin
                i_dv   = 1'b1;
                i_data = h_dv ? h_data_in : '0;
            end else begin
                d_dv = 1'b1;
                if (state_q == S_GNT_DR && h_dv) begin
                    d_rdata = h_data_in;
                end
            end
            if (state_q == S_GNT_DW) begin
                inv_d      = 1'b1;
                inv_addr_d = h_addr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            h_addr_q     <= '0;
            h_data_out_q <= '0;
            inv_addr_q   <= '0;
            inv_q        <= 1'b0;
            err_q        <= 1'b0;
            last_q       <= LS_D;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            h_addr_q     <= h_addr_d;
            h_data_out_q <= h_data_out_d;
            inv_addr_q   <= inv_addr_d;
            inv_q        <= inv_d;
            err_q        <= err_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
        end
    end

    assign h_rd       = (state_q == S_GNT_I) || (state_q == S_GNT_DR);
    assign h_wr       = (state_q == S_GNT_DW);
    assign h_addr     = h_addr_q;
    assign h_data_out = h_data_out_q;
    assign inv_addr   = inv_addr_q;
    assign inv        = inv_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cmem_arbiter.sv
// Directed bench for cmem_arbiter: single grants, tie-break, writeback + invalidate, timeout, reset abort, alternation.
module tb_cmem_arbiter;

    localparam int AW = 64;
    localparam int LW = 256;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_addr = '0;
    logic          i_rd = 1'b0;
    logic [LW-1:0] i_data;
    logic          i_dv;
    logic [AW-1:0] d_addr = '0;
    logic          d_rd = 1'b0;
    logic          d_wr = 1'b0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_dv;
    logic [AW-1:0] h_addr;
    logic          h_rd;
    logic          h_wr;
    logic [LW-1:0] h_data_out;
    logic [LW-1:0] h_data_in = '0;
    logic          h_dv = 1'b0;
    logic [AW-1:0] inv_addr;
    logic          inv;
    logic          err;

    int n_chk  = 0;
    int n_pass = 0;

    cmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_dv(d_dv),
        .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_data_out(h_data_out),
        .h_data_in(h_data_in), .h_dv(h_dv),
        .inv_addr(inv_addr), .inv(inv), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] p1, p2, w1;
        int hi, ndv, found;
        p1 = {8{32'hA5A5_0001}};
        p2 = {8{32'h5A5A_0002}};
        w1 = {8{32'hC0DE_0003}};

        // Reset state
        tick(); tick();
        #1;
        chk("rst_h_rd", h_rd, 0);
        chk("rst_h_wr", h_wr, 0);
        chk("rst_h_addr", h_addr, 0);
        chk("rst_h_data_out", h_data_out, 0);
        chk("rst_inv_addr", inv_addr, 0);
        chk("rst_inv", inv, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Stray h_dv in IDLE is ignored
        h_dv = 1'b1; h_data_in = p1;
        #1;
        chk("idle_hdv_i_dv", i_dv, 0);
        chk("idle_hdv_d_dv", d_dv, 0);
        chk("idle_hdv_i_data", i_data, 0);
        h_dv = 1'b0;

        // T1: single I refill, h_dv on 4th grant cycle
        i_addr = 64'h1234; i_rd = 1'b1;
        tick();
        chk("t1_h_rd_c1", h_rd, 1);
        chk("t1_h_addr", h_addr, 64'h1220);
        chk("t1_i_dv_c1", i_dv, 0);
        tick(); chk("t1_h_rd_c2", h_rd, 1);
        tick(); chk("t1_h_rd_c3", h_rd, 1);
        tick();
        h_dv = 1'b1; h_data_in = p1;
        #1;
        chk("t1_h_rd_c4", h_rd, 1);
        chk("t1_i_dv", i_dv, 1);
        chk("t1_i_data", i_data, p1);
        chk("t1_d_dv", d_dv, 0);
        tick();
        h_dv = 1'b0; i_rd = 1'b0;
        #1;
        chk("t1_release_h_rd", h_rd, 0);
        chk("t1_i_dv_off", i_dv, 0);
        chk("t1_i_data_off", i_data, 0);
        tick();

        // T2: simultaneous I and D read from reset; I wins, 2-cycle gap
        rst = 1'b1; tick(); rst = 1'b0;
        i_addr = 64'h40; d_addr = 64'h85; i_rd = 1'b1; d_rd = 1'b1;
        tick();
        chk("t2_first_h_rd", h_rd, 1);
        chk("t2_first_addr", h_addr, 64'h40);
        h_dv = 1'b1; h_data_in = p1;
        #1;
        chk("t2_i_dv", i_dv, 1);
        chk("t2_d_dv_first", d_dv, 0);
        tick();
        h_dv = 1'b0; i_rd = 1'b0;
        chk("t2_gap1", h_rd, 0);
        tick();
        chk("t2_gap2", h_rd, 0);
        tick();
        chk("t2_second_h_rd", h_rd, 1);
        chk("t2_second_addr", h_addr, 64'h80);
        h_dv = 1'b1; h_data_in = p2;
        #1;
        chk("t2_d_dv", d_dv, 1);
        chk("t2_d_rdata", d_rdata, p2);
        chk("t2_i_dv_second", i_dv, 0);
        tick();
        h_dv = 1'b0; d_rd = 1'b0;
        chk("t2_no_inv_read", inv, 0);
        tick();

        // T3: d_rd and d_wr together -> writeback, then invalidate
        d_addr = 64'h80; d_rd = 1'b1; d_wr = 1'b1; d_wdata = w1;
        tick();
        chk("t3_h_wr", h_wr, 1);
        chk("t3_h_rd", h_rd, 0);
        chk("t3_h_addr", h_addr, 64'h80);
        chk("t3_h_data_out", h_data_out, w1);
        d_wdata = p1;
        tick();
        chk("t3_data_held", h_data_out, w1);
        h_dv = 1'b1; h_data_in = p2;
        #1;
        chk("t3_d_dv", d_dv, 1);
        chk("t3_d_rdata_zero", d_rdata, 0);
        chk("t3_inv_not_yet", inv, 0);
        tick();
        h_dv = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        chk("t3_inv", inv, 1);
        chk("t3_inv_addr", inv_addr, 64'h80);
        chk("t3_h_wr_off", h_wr, 0);
        tick();
        chk("t3_inv_pulse", inv, 0);
        tick();

        // T4: timeout with no h_dv
        i_addr = 64'h200; i_rd = 1'b1;
        hi = 0; ndv = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (h_rd) hi++;
            if (i_dv) begin
                ndv++;
                chk("t4_i_data_zero", i_data, 0);
                i_rd = 1'b0;
            end
            if (!h_rd && hi > 0) break;
        end
        chk("t4_h_rd_cycles", hi, 8);
        chk("t4_i_dv_count", ndv, 1);
        chk("t4_err", err, 1);
        tick(); tick(); tick();
        chk("t4_err_sticky", err, 1);

        // T5: reset mid GNT_DR
        d_addr = 64'h300; d_rd = 1'b1;
        tick();
        chk("t5_h_rd", h_rd, 1);
        tick();
        rst = 1'b1; h_dv = 1'b1; h_data_in = p1;
        #1;
        chk("t5_no_d_dv_in_rst", d_dv, 0);
        tick();
        chk("t5_h_rd_dropped", h_rd, 0);
        chk("t5_err_cleared", err, 0);
        chk("t5_no_inv", inv, 0);
        rst = 1'b0; h_dv = 1'b0; d_rd = 1'b0;
        tick();
        chk("t5_no_d_dv_after", d_dv, 0);
        chk("t5_idle_h_rd", h_rd, 0);

        // T6: continuous requests alternate I,D,I,D,I,D
        i_addr = 64'h1000; d_addr = 64'h2000; i_rd = 1'b1; d_rd = 1'b1;
        for (int g = 0; g < 6; g++) begin
            found = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (h_rd) begin
                    found = 1;
                    break;
                end
            end
            chk("t6_grant", h_rd, 1);
            chk("t6_order", h_addr, (g % 2 == 0) ? 64'h1000 : 64'h2000);
            if (found != 0) begin
                h_dv = 1'b1; h_data_in = p2;
                #1;
                chk("t6_dv", (g % 2 == 0) ? i_dv : d_dv, 1);
                tick();
                h_dv = 1'b0;
            end
        end
        i_rd = 1'b0; d_rd = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
